// File: rtl/ring_writer.sv
`timescale 1ns/1ps
// ring_writer
//   Producer for a shared-memory ring buffer. Accepts 32-bit command words
//   over valid/ready, waits for space by polling the reader-owned read
//   pointer, writes the word into the next slot and only then publishes the
//   advanced write pointer, so a reader never sees a pointer ahead of data.
//
//   Memory layout: read pointer at RP_ADDR, write pointer at WP_ADDR,
//   2^PTR_W data slots starting at BASE_ADDR. Usable capacity 2^PTR_W-1.
//
// Ports
//   clk            clock, all logic on posedge
//   rst            asynchronous active-low reset
//   in_data        command word from upstream
//   in_valid       in_data valid
//   in_ready       block can accept a word this cycle
//   mem_DataOut    memory read data, valid with mem_done
//   mem_done       memory access complete (1-cycle pulse)
//   mem_enable     one-cycle access request pulse
//   mem_readWrite  1 = read, 0 = write
//   mem_address    access address
//   mem_DataWrite  write data
//   buffer_full    last read-pointer poll found the ring full
//   init_done      pointer initialisation complete
//   words_written  count of committed words (wraps at 2^16)
module ring_writer #(
  parameter int unsigned PTR_W     = 4,
  parameter logic [14:0] RP_ADDR   = 15'h0001,
  parameter logic [14:0] WP_ADDR   = 15'h0002,
  parameter logic [14:0] BASE_ADDR = 15'h0003,
  parameter int unsigned TIMEOUT   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] mem_DataOut,
  input  logic        mem_done,
  output logic        mem_enable,
  output logic        mem_readWrite,
  output logic [14:0] mem_address,
  output logic [31:0] mem_DataWrite,
  output logic        buffer_full,
  output logic        init_done,
  output logic [15:0] words_written
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INIT_RP,
    S_INIT_RP_W,
    S_INIT_WP,
    S_INIT_WP_W,
    S_IDLE,
    S_READ_RP,
    S_READ_RP_W,
    S_CHECK,
    S_WRITE_DATA,
    S_WRITE_DATA_W,
    S_WRITE_WP,
    S_WRITE_WP_W
  } state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   wp, wp_n;
  logic [PTR_W-1:0]   rp, rp_n;
  logic [DATA_W-1:0]  held, held_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic               mem_enable_n;
  logic               mem_readWrite_n;
  logic [ADDR_W-1:0]  mem_address_n;
  logic [DATA_W-1:0]  mem_DataWrite_n;
  logic               in_ready_n;
  logic               buffer_full_n;
  logic               init_done_n;
  logic [15:0]        words_written_n;

  logic [PTR_W-1:0]   wp_inc;
  logic               acc_done;
  logic               acc_timeout;
  logic               unused_rd_bits;

  function automatic logic is_wait(input state_t s);
    return (s == S_INIT_RP_W) || (s == S_INIT_WP_W) || (s == S_READ_RP_W) ||
           (s == S_WRITE_DATA_W) || (s == S_WRITE_WP_W);
  endfunction

  assign wp_inc = wp + PTR_W'(1);

  // mem_enable is still high during the first cycle of every wait state (the
  // request cycle); mem_done is only honoured once the request has dropped.
  assign acc_done    = !mem_enable && mem_done;
  assign acc_timeout = !mem_enable && !mem_done && (cnt == CNT_LAST);

  // Only the pointer-sized low bits of the read pointer word are meaningful.
  assign unused_rd_bits = ^mem_DataOut[DATA_W-1:PTR_W];

  always_comb begin
    state_n         = state;
    wp_n            = wp;
    rp_n            = rp;
    held_n          = held;
    cnt_n           = cnt;
    mem_enable_n    = 1'b0;
    mem_readWrite_n = mem_readWrite;
    mem_address_n   = mem_address;
    mem_DataWrite_n = mem_DataWrite;
    in_ready_n      = in_ready;
    buffer_full_n   = buffer_full;
    init_done_n     = init_done;
    words_written_n = words_written;

    // Shared access watchdog for every wait state.
    if (is_wait(state) && !mem_enable) begin
      if (mem_done || acc_timeout) begin
        cnt_n = '0;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end

    case (state)
      S_INIT_RP: begin
        mem_enable_n    = 1'b1;
        mem_readWrite_n = 1'b0;
        mem_address_n   = RP_ADDR;
        mem_DataWrite_n = '0;
        state_n         = S_INIT_RP_W;
      end

      S_INIT_RP_W: begin
        if (acc_done) begin
          state_n = S_INIT_WP;
        end else if (acc_timeout) begin
          state_n = S_INIT_RP;
        end
      end

      S_INIT_WP: begin
        mem_enable_n    = 1'b1;
        mem_readWrite_n = 1'b0;
        mem_address_n   = WP_ADDR;
        mem_DataWrite_n = '0;
        state_n         = S_INIT_WP_W;
      end

      S_INIT_WP_W: begin
        if (acc_done) begin
          init_done_n = 1'b1;
          in_ready_n  = 1'b1;
          state_n     = S_IDLE;
        end else if (acc_timeout) begin
          state_n = S_INIT_WP;
        end
      end

      S_IDLE: begin
        // One word per transaction: ready stays low until the commit.
        if (in_valid && in_ready) begin
          held_n     = in_data;
          in_ready_n = 1'b0;
          state_n    = S_READ_RP;
        end
      end

      S_READ_RP: begin
        mem_enable_n    = 1'b1;
        mem_readWrite_n = 1'b1;
        mem_address_n   = RP_ADDR;
        mem_DataWrite_n = '0;
        state_n         = S_READ_RP_W;
      end

      S_READ_RP_W: begin
        if (acc_done) begin
          rp_n    = mem_DataOut[PTR_W-1:0];
          state_n = S_CHECK;
        end else if (acc_timeout) begin
          state_n = S_READ_RP;
        end
      end

      S_CHECK: begin
        // One slot is always left empty so full and empty are distinguishable.
        if (wp_inc == rp) begin
          buffer_full_n = 1'b1;
          state_n       = S_READ_RP;
        end else begin
          buffer_full_n = 1'b0;
          state_n       = S_WRITE_DATA;
        end
      end

      S_WRITE_DATA: begin
        mem_enable_n    = 1'b1;
        mem_readWrite_n = 1'b0;
        mem_address_n   = BASE_ADDR + {{(ADDR_W-PTR_W){1'b0}}, wp};
        mem_DataWrite_n = held;
        state_n         = S_WRITE_DATA_W;
      end

      S_WRITE_DATA_W: begin
        if (acc_done) begin
          state_n = S_WRITE_WP;
        end else if (acc_timeout) begin
          // Restart from the poll; the held word and wp are untouched.
          state_n = S_READ_RP;
        end
      end

      S_WRITE_WP: begin
        mem_enable_n    = 1'b1;
        mem_readWrite_n = 1'b0;
        mem_address_n   = WP_ADDR;
        mem_DataWrite_n = {{(DATA_W-PTR_W){1'b0}}, wp_inc};
        state_n         = S_WRITE_WP_W;
      end

      S_WRITE_WP_W: begin
        if (acc_done) begin
          wp_n            = wp_inc;
          words_written_n = words_written + 16'd1;
          in_ready_n      = 1'b1;
          state_n         = S_IDLE;
        end else if (acc_timeout) begin
          // Data already landed; only the pointer publish is retried.
          state_n = S_WRITE_WP;
        end
      end

      default: begin
        state_n = S_INIT_RP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_INIT_RP;
      wp            <= '0;
      rp            <= '0;
      held          <= '0;
      cnt           <= '0;
      mem_enable    <= 1'b0;
      mem_readWrite <= 1'b1;
      mem_address   <= '0;
      mem_DataWrite <= '0;
      in_ready      <= 1'b0;
      buffer_full   <= 1'b0;
      init_done     <= 1'b0;
      words_written <= '0;
    end else begin
      state         <= state_n;
      wp            <= wp_n;
      rp            <= rp_n;
      held          <= held_n;
      cnt           <= cnt_n;
      mem_enable    <= mem_enable_n;
      mem_readWrite <= mem_readWrite_n;
      mem_address   <= mem_address_n;
      mem_DataWrite <= mem_DataWrite_n;
      in_ready      <= in_ready_n;
      buffer_full   <= buffer_full_n;
      init_done     <= init_done_n;
      words_written <= words_written_n;
    end
  end

endmodule

// File: tb/tb_ring_writer.sv
`timescale 1ns/1ps
// Testbench for ring_writer: memory model with fixed response latency,
// expected-access scoreboard checked by a forked monitor, directed stimulus.
module tb_ring_writer;

  localparam logic [14:0] RP   = 15'h0001;
  localparam logic [14:0] WP   = 15'h0002;
  localparam logic [14:0] BASE = 15'h0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mem_DataOut = '0;
  logic        mem_done = 1'b0;
  logic        mem_enable;
  logic        mem_readWrite;
  logic [14:0] mem_address;
  logic [31:0] mem_DataWrite;
  logic        buffer_full;
  logic        init_done;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  ring_writer #(
    .PTR_W(4), .RP_ADDR(RP), .WP_ADDR(WP), .BASE_ADDR(BASE), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_DataOut(mem_DataOut), .mem_done(mem_done),
    .mem_enable(mem_enable), .mem_readWrite(mem_readWrite),
    .mem_address(mem_address), .mem_DataWrite(mem_DataWrite),
    .buffer_full(buffer_full), .init_done(init_done),
    .words_written(words_written)
  );

  typedef struct packed {
    logic        rw;
    logic [14:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   poll_cnt = 0;
  bit   allow_poll = 1'b0;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:31] = '{default: 32'h0};
  int          poke_seq = 0, poke_seen = 0;
  int          drop_seq = 0, drop_seen = 0;
  logic [4:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  bit          hang = 1'b0;
  bit          drop_armed = 1'b0;
  bit          pend = 1'b0;
  logic        p_rw = 1'b0;
  logic [14:0] p_addr = '0;
  logic [31:0] p_data = '0;
  int          lat = 0;

  always @(negedge clk) begin
    mem_done = 1'b0;
    if (poke_seq != poke_seen) begin
      mem[poke_addr] = poke_data;
      poke_seen = poke_seq;
    end
    if (drop_seq != drop_seen) begin
      drop_armed = 1'b1;
      drop_seen = drop_seq;
    end
    if (!rst) begin
      pend = 1'b0;
    end else if (mem_enable) begin
      pend = 1'b1;
      p_rw = mem_readWrite;
      p_addr = mem_address;
      p_data = mem_DataWrite;
      lat = 2;
    end else if (pend) begin
      lat--;
      if (lat == 0) begin
        pend = 1'b0;
        if (p_rw) begin
          mem_DataOut = mem[p_addr[4:0]];
          mem_done = 1'b1;
        end else if (p_addr >= BASE && hang) begin
          // swallowed: never answered
        end else if (p_addr >= BASE && drop_armed) begin
          drop_armed = 1'b0;
        end else begin
          mem[p_addr[4:0]] = p_data;
          mem_done = 1'b1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_acc(input logic rw, input logic [14:0] addr, input logic [31:0] data);
    acc_t a;
    a.rw = rw;
    a.addr = addr;
    a.data = data;
    exp_q.push_back(a);
  endtask

  task automatic monitor();
    logic prev_en;
    acc_t a;
    acc_t e;
    bit   ok;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && mem_enable) begin
        a.rw = mem_readWrite;
        a.addr = mem_address;
        a.data = mem_DataWrite;
        if (allow_poll && a.rw && a.addr == RP && !prev_en) begin
          poll_cnt++;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL access unexpected rw=%0b addr=%h data=%h required none",
                   a.rw, a.addr, a.data);
        end else begin
          e = exp_q.pop_front();
          ok = (a.rw === e.rw) && (a.addr === e.addr) && !prev_en &&
               (e.rw || a.data === e.data);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL access actual rw=%0b addr=%h data=%h prev_en=%0b required rw=%0b addr=%h data=%h",
                     a.rw, a.addr, a.data, prev_en, e.rw, e.addr, e.data);
          end
        end
      end
      prev_en = mem_enable;
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready actual=0 required=1 word=%h", w);
    end else begin
      in_data = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_ww(input logic [15:0] target, input string name);
    int n;
    n = 0;
    while (words_written !== target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {16'h0, words_written}, {16'h0, target});
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, init_done}, 32'h1);
  endtask

  task automatic poke(input logic [4:0] addr, input logic [31:0] data);
    poke_addr = addr;
    poke_data = data;
    poke_seq++;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    fork
      monitor();
    join_none

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
    check("rst_readWrite", {31'h0, mem_readWrite}, 32'h1);
    check("rst_address", {17'h0, mem_address}, 32'h0);
    check("rst_DataWrite", mem_DataWrite, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_buffer_full", {31'h0, buffer_full}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_words", {16'h0, words_written}, 32'h0);

    // Initialisation: both pointers written to zero.
    expect_acc(1'b0, RP, 32'h0);
    expect_acc(1'b0, WP, 32'h0);
    rst = 1'b1;
    wait_init("init_done");
    check("init_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (5) @(negedge clk);
    check("init_queue_empty", exp_q.size(), 32'h0);

    // Single word.
    expect_acc(1'b1, RP, 32'h0);
    expect_acc(1'b0, BASE, 32'hDEADBEEF);
    expect_acc(1'b0, WP, 32'h1);
    send(32'hDEADBEEF);
    wait_ww(16'd1, "words_after_first");
    repeat (2) @(negedge clk);
    check("first_in_ready", {31'h0, in_ready}, 32'h1);
    check("first_mem_wp", mem[2], 32'h1);
    check("first_mem_slot", mem[3], 32'hDEADBEEF);

    // Data write abandoned once, retried from the poll.
    drop_seq++;
    expect_acc(1'b1, RP, 32'h0);
    expect_acc(1'b0, 15'h0004, 32'hC0FFEE01);
    expect_acc(1'b1, RP, 32'h0);
    expect_acc(1'b0, 15'h0004, 32'hC0FFEE01);
    expect_acc(1'b0, WP, 32'h2);
    send(32'hC0FFEE01);
    wait_ww(16'd2, "words_after_timeout");
    repeat (20) @(negedge clk);
    check("timeout_words_once", {16'h0, words_written}, 32'h2);
    check("timeout_mem_wp", mem[2], 32'h2);
    check("timeout_mem_slot", mem[4], 32'hC0FFEE01);

    // Reset while a data write is outstanding.
    hang = 1'b1;
    expect_acc(1'b1, RP, 32'h0);
    expect_acc(1'b0, 15'h0005, 32'h5A5A0005);
    send(32'h5A5A0005);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hang_write_issued", exp_q.size(), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_enable", {31'h0, mem_enable}, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    check("midrst_init_done", {31'h0, init_done}, 32'h0);
    check("midrst_readWrite", {31'h0, mem_readWrite}, 32'h1);
    check("midrst_words", {16'h0, words_written}, 32'h0);
    expect_acc(1'b0, RP, 32'h0);
    expect_acc(1'b0, WP, 32'h0);
    repeat (2) @(negedge clk);
    hang = 1'b0;
    rst = 1'b1;
    wait_init("reinit_done");
    repeat (2) @(negedge clk);
    check("reinit_mem_wp", mem[2], 32'h0);
    check("reinit_mem_rp", mem[1], 32'h0);

    // Fill the ring to capacity (15 words).
    for (int i = 0; i < 15; i++) begin
      expect_acc(1'b1, RP, 32'h0);
      expect_acc(1'b0, BASE + 15'(i), 32'h1000_0000 + 32'(i));
      expect_acc(1'b0, WP, 32'(i + 1));
      send(32'h1000_0000 + 32'(i));
    end
    wait_ww(16'd15, "words_after_fill");
    repeat (2) @(negedge clk);
    check("fill_mem_wp", mem[2], 32'd15);
    check("fill_slot0", mem[3], 32'h1000_0000);
    check("fill_slot14", mem[17], 32'h1000_000E);

    // 16th word finds the ring full and polls until space appears.
    allow_poll = 1'b1;
    expect_acc(1'b0, 15'd18, 32'hF00D000F);
    expect_acc(1'b0, WP, 32'h0);
    send(32'hF00D000F);
    repeat (30) @(negedge clk);
    check("full_flag", {31'h0, buffer_full}, 32'h1);
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    check("full_polls", {31'h0, poll_cnt >= 2}, 32'h1);
    check("full_words", {16'h0, words_written}, 32'd15);
    // Offered word while not ready must be ignored.
    in_data = 32'hBAD0BAD0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    poke(5'd1, 32'h1);
    wait_ww(16'd16, "words_after_full");
    repeat (2) @(negedge clk);
    check("unfull_flag", {31'h0, buffer_full}, 32'h0);
    check("unfull_mem_wp", mem[2], 32'h0);
    check("unfull_slot15", mem[18], 32'hF00D000F);

    // Wrapped pointer: next word lands in slot 0.
    allow_poll = 1'b0;
    poke(5'd1, 32'h5);
    expect_acc(1'b1, RP, 32'h0);
    expect_acc(1'b0, BASE, 32'hCAFE0004);
    expect_acc(1'b0, WP, 32'h1);
    send(32'hCAFE0004);
    wait_ww(16'd17, "words_after_wrap");
    repeat (2) @(negedge clk);
    check("wrap_mem_wp", mem[2], 32'h1);
    check("wrap_slot0", mem[3], 32'hCAFE0004);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
